// File: rtl/iot_event_arbiter.sv
// Round-robin serialiser of per-device connect/disconnect events into a single change/on_off stream.
// Optional duplicate-event suppression is enabled by defining IOT_ARB_DEDUP_EN.
module iot_event_arbiter #(
  parameter int N_DEV = 8,
  parameter int ID_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_DEV-1:0]  dev_evt,
  input  logic [N_DEV-1:0]  dev_state,
  output logic              change,
  output logic              on_off,
  output logic [ID_W-1:0]   dev_id,
  output logic [N_DEV-1:0]  active_mask,
  output logic              overrun
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_DEV - 1);

  logic [N_DEV-1:0] pend_q, pend_d;
  logic [N_DEV-1:0] pval_q, pval_d;
  logic [N_DEV-1:0] mask_q, mask_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             change_q, change_d;
  logic             on_off_q, on_off_d;
  logic [ID_W-1:0]  dev_id_q, dev_id_d;
  logic             overrun_q, overrun_d;

  logic             grant;
  logic [ID_W-1:0]  gnt;
  logic [N_DEV-1:0] gnt_oh;
  logic             redundant;

  // Search pend starting at ptr, wrapping; first hit wins.
  always_comb begin
    int unsigned idx;
    grant  = 1'b0;
    gnt    = '0;
    gnt_oh = '0;
    idx    = 0;
    for (int unsigned k = 0; k < N_DEV; k++) begin
      idx = k + 32'(ptr_q);
      if (idx >= N_DEV) idx = idx - N_DEV;
      if (!grant && pend_q[idx[ID_W-1:0]]) begin
        grant = 1'b1;
        gnt   = idx[ID_W-1:0];
      end
    end
    if (grant) gnt_oh[gnt] = 1'b1;
  end

  always_comb begin
    pend_d    = pend_q;
    pval_d    = pval_q;
    mask_d    = mask_q;
    ptr_d     = ptr_q;
    change_d  = 1'b0;
    on_off_d  = on_off_q;
    dev_id_d  = dev_id_q;
    overrun_d = |(dev_evt & pend_q & ~gnt_oh);
    redundant = 1'b0;

    if (grant) begin
`ifdef IOT_ARB_DEDUP_EN
      redundant = (pval_q[gnt] == mask_q[gnt]);
`else
      redundant = 1'b0;
`endif
      pend_d[gnt] = 1'b0;
      mask_d[gnt] = pval_q[gnt];
      ptr_d       = (gnt == LAST_ID) ? '0 : gnt + ID_W'(1);
      if (!redundant) begin
        change_d = 1'b1;
        on_off_d = pval_q[gnt];
        dev_id_d = gnt;
      end
    end

    // New captures follow the grant so a same-edge event re-arms the slot.
    for (int unsigned i = 0; i < N_DEV; i++) begin
      if (dev_evt[i]) begin
        pend_d[i] = 1'b1;
        pval_d[i] = dev_state[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q    <= '0;
      pval_q    <= '0;
      mask_q    <= '0;
      ptr_q     <= '0;
      change_q  <= 1'b0;
      on_off_q  <= 1'b0;
      dev_id_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      pval_q    <= pval_d;
      mask_q    <= mask_d;
      ptr_q     <= ptr_d;
      change_q  <= change_d;
      on_off_q  <= on_off_d;
      dev_id_q  <= dev_id_d;
      overrun_q <= overrun_d;
    end
  end

  assign change      = change_q;
  assign on_off      = on_off_q;
  assign dev_id      = dev_id_q;
  assign active_mask = mask_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_iot_event_arbiter.sv
// Directed self-checking bench for iot_event_arbiter (N_DEV=8); expectations follow IOT_ARB_DEDUP_EN.
module tb_iot_event_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] dev_evt;
  logic [7:0] dev_state;
  logic       change;
  logic       on_off;
  logic [2:0] dev_id;
  logic [7:0] active_mask;
  logic       overrun;

  int n_cmp = 0;
  int n_err = 0;

  iot_event_arbiter #(.N_DEV(8), .ID_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .dev_evt     (dev_evt),
    .dev_state   (dev_state),
    .change      (change),
    .on_off      (on_off),
    .dev_id      (dev_id),
    .active_mask (active_mask),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input logic [2:0] id, input logic val);
    chk({tag, ".change"}, 32'(change), 32'd1);
    chk({tag, ".dev_id"}, 32'(dev_id), 32'(id));
    chk({tag, ".on_off"}, 32'(on_off), 32'(val));
  endtask

  initial begin
    rst       = 1'b0;
    dev_evt   = 8'hFF;
    dev_state = 8'hFF;

    // Reset held with all events asserted
    repeat (4) tick();
    chk("rst.change",  32'(change),      32'd0);
    chk("rst.on_off",  32'(on_off),      32'd0);
    chk("rst.dev_id",  32'(dev_id),      32'd0);
    chk("rst.mask",    32'(active_mask), 32'd0);
    chk("rst.overrun", 32'(overrun),     32'd0);
    rst     = 1'b1;
    dev_evt = 8'h00;
    tick();
    chk("post_rst.change0", 32'(change), 32'd0);
    tick();
    chk("post_rst.change1", 32'(change), 32'd0);

    // Single event on device 3
    dev_evt = 8'h08; dev_state = 8'h08;
    tick();
    dev_evt = 8'h00;
    tick();
    chk_evt("single", 3'd3, 1'b1);
    chk("single.mask", 32'(active_mask), 32'h08);
    tick();
    chk("single.idle", 32'(change), 32'd0);

    // Device 7 connect moves ptr back to 0
    dev_evt = 8'h80; dev_state = 8'h80;
    tick();
    dev_evt = 8'h00;
    tick();
    chk_evt("dev7", 3'd7, 1'b1);
    chk("dev7.mask", 32'(active_mask), 32'h88);

    // Contention: 1, 5, 6 together
    dev_evt = 8'b0110_0010; dev_state = 8'hFF;
    tick();
    dev_evt = 8'h00;
    tick();
    chk_evt("cont0", 3'd1, 1'b1);
    tick();
    chk_evt("cont1", 3'd5, 1'b1);
    tick();
    chk_evt("cont2", 3'd6, 1'b1);
    chk("cont.mask", 32'(active_mask), 32'hEA);

    // Fairness: ptr=7, so 7 (disconnect) precedes 0 (connect)
    dev_evt = 8'h81; dev_state = 8'h01;
    tick();
    dev_evt = 8'h00;
    tick();
    chk_evt("fair0", 3'd7, 1'b0);
    tick();
    chk_evt("fair1", 3'd0, 1'b1);
    chk("fair.mask", 32'(active_mask), 32'h6B);

    // Connect device 2 so its later disconnect is not a duplicate
    dev_evt = 8'h04; dev_state = 8'h04;
    tick();
    dev_evt = 8'h00;
    tick();
    chk_evt("dev2", 3'd2, 1'b1);
    chk("dev2.mask", 32'(active_mask), 32'h6F);

    // Overrun: 1 and 2 pending, device 2 re-reported while 1 is granted
    dev_evt = 8'h06; dev_state = 8'h04;
    tick();
    dev_evt = 8'h04; dev_state = 8'h00;
    tick();
    dev_evt = 8'h00;
    chk_evt("ovr.g1", 3'd1, 1'b0);
    chk("ovr.pulse", 32'(overrun), 32'd1);
    tick();
    chk_evt("ovr.g2", 3'd2, 1'b0);
    chk("ovr.pulse_end", 32'(overrun), 32'd0);
    chk("ovr.mask", 32'(active_mask), 32'h69);
    tick();
    chk("ovr.single_fwd", 32'(change), 32'd0);

    // Dedup: device 4 reports connect twice back to back
    dev_evt = 8'h10; dev_state = 8'h10;
    tick();
    tick();
    dev_evt = 8'h00;
    chk_evt("dup0", 3'd4, 1'b1);
    chk("dup0.overrun", 32'(overrun), 32'd0);
    chk("dup0.mask", 32'(active_mask), 32'h79);
    tick();
`ifdef IOT_ARB_DEDUP_EN
    chk("dup1.suppressed", 32'(change), 32'd0);
`else
    chk_evt("dup1", 3'd4, 1'b1);
`endif
    chk("dup1.mask", 32'(active_mask), 32'h79);
    tick();
    chk("dup.idle", 32'(change), 32'd0);

    // Reset with five events pending
    dev_evt = 8'h1F; dev_state = 8'h00;
    tick();
    dev_evt = 8'h00;
    rst     = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst.change", 32'(change),      32'd0);
    chk("midrst.mask",   32'(active_mask), 32'd0);
    tick();
    chk("midrst.drop0", 32'(change), 32'd0);
    tick();
    chk("midrst.drop1", 32'(change), 32'd0);
    dev_evt = 8'h40; dev_state = 8'h40;
    tick();
    dev_evt = 8'h00;
    tick();
    chk_evt("midrst.evt", 3'd6, 1'b1);
    chk("midrst.evt_mask", 32'(active_mask), 32'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
